// File: rtl/adc_sense_frontend.sv
// Multi-channel ADC sensing front-end: sign/offset conditioning with saturation,
// block averaging, out-of-range stretch/sticky flags and an offset-binary DAC mirror.
module adc_sense_frontend #(
    parameter int N_CH     = 2,
    parameter int DATA_W   = 14,
    parameter int AVG_LOG2 = 2,
    parameter int OR_HOLD  = 5_000_000
) (
    input  logic                     i_clock,
    input  logic                     i_RESET,
    input  logic                     i_enable,
    input  logic [N_CH*DATA_W-1:0]   i_data,
    input  logic [N_CH-1:0]          i_valid,
    input  logic [N_CH-1:0]          i_or,
    input  logic [N_CH-1:0]          i_invert,
    input  logic [N_CH*DATA_W-1:0]   i_offset,
    input  logic                     i_or_clear,
    input  logic [2*N_CH-1:0]        i_dac_sel,
    input  logic [N_CH*DATA_W-1:0]   i_debug,
    output logic [N_CH*DATA_W-1:0]   o_sample,
    output logic [N_CH-1:0]          o_valid,
    output logic [N_CH*DATA_W-1:0]   o_avg,
    output logic [N_CH-1:0]          o_avg_valid,
    output logic [N_CH-1:0]          o_or_flag,
    output logic [N_CH-1:0]          o_or_sticky,
    output logic [N_CH*DATA_W-1:0]   o_dac
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int OR_W  = $clog2(OR_HOLD + 1);

    localparam logic signed [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0]        DAC_MID = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [OR_W-1:0]          OR_LOAD = OR_W'(OR_HOLD);

    genvar c;
    for (c = 0; c < N_CH; c++) begin : g_ch
        logic signed [DATA_W-1:0] d_in, off_in, dbg_in;
        logic [1:0]               sel_in;
        logic                     or_event;

        logic signed [DATA_W-1:0] x_q, x_d;
        logic                     v1_q, v1_d;
        logic signed [DATA_W-1:0] samp_q, samp_d;
        logic                     valid_q, valid_d;
        logic signed [ACC_W-1:0]  acc_q, acc_d;
        logic [CNT_W-1:0]         cnt_q, cnt_d;
        logic signed [DATA_W-1:0] avg_q, avg_d;
        logic                     avgv_q, avgv_d;
        logic [OR_W-1:0]          orc_q, orc_d;
        logic                     sticky_q, sticky_d;
        logic [DATA_W-1:0]        dac_q, dac_d;

        logic [DATA_W:0]          diff;
        logic signed [ACC_W-1:0]  samp_ext, sum_full, avg_full;
        logic signed [DATA_W-1:0] dac_src;

        assign d_in     = i_data[c*DATA_W +: DATA_W];
        assign off_in   = i_offset[c*DATA_W +: DATA_W];
        assign dbg_in   = i_debug[c*DATA_W +: DATA_W];
        assign sel_in   = i_dac_sel[2*c +: 2];
        assign or_event = i_valid[c] & i_or[c];
        assign samp_ext = ACC_W'(samp_q);
        assign sum_full = acc_q + samp_ext;
        assign avg_full = sum_full >>> AVG_LOG2;

        always_comb begin
            x_d = x_q;
            if (i_valid[c]) begin
                if (i_invert[c]) begin
                    x_d = (d_in == S_MIN) ? S_MAX : -d_in;
                end else begin
                    x_d = d_in;
                end
            end
            v1_d = i_valid[c];

            // One guard bit: overflow shows as the top two bits disagreeing.
            diff   = {x_q[DATA_W-1], x_q} - {off_in[DATA_W-1], off_in};
            samp_d = samp_q;
            if (v1_q) begin
                if (diff[DATA_W] != diff[DATA_W-1]) begin
                    samp_d = diff[DATA_W] ? S_MIN : S_MAX;
                end else begin
                    samp_d = diff[DATA_W-1:0];
                end
            end
            valid_d = v1_q & i_enable;

            acc_d  = acc_q;
            cnt_d  = cnt_q;
            avg_d  = avg_q;
            avgv_d = 1'b0;
            if (!i_enable) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (valid_q) begin
                if (cnt_q == CNT_LAST) begin
                    avg_d  = avg_full[DATA_W-1:0];
                    avgv_d = 1'b1;
                    acc_d  = '0;
                    cnt_d  = '0;
                end else begin
                    acc_d = sum_full;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            if (or_event) begin
                orc_d = OR_LOAD;
            end else if (orc_q != '0) begin
                orc_d = orc_q - OR_W'(1);
            end else begin
                orc_d = '0;
            end

            if (or_event) begin
                sticky_d = 1'b1;
            end else if (i_or_clear) begin
                sticky_d = 1'b0;
            end else begin
                sticky_d = sticky_q;
            end

            case (sel_in)
                2'd0:    dac_src = samp_q;
                2'd1:    dac_src = avg_q;
                2'd2:    dac_src = dbg_in;
                default: dac_src = '0;
            endcase
            dac_d = {~dac_src[DATA_W-1], dac_src[DATA_W-2:0]};
        end

        always_ff @(posedge i_clock) begin
            if (i_RESET) begin
                x_q      <= '0;
                v1_q     <= 1'b0;
                samp_q   <= '0;
                valid_q  <= 1'b0;
                acc_q    <= '0;
                cnt_q    <= '0;
                avg_q    <= '0;
                avgv_q   <= 1'b0;
                orc_q    <= '0;
                sticky_q <= 1'b0;
                dac_q    <= DAC_MID;
            end else begin
                x_q      <= x_d;
                v1_q     <= v1_d;
                samp_q   <= samp_d;
                valid_q  <= valid_d;
                acc_q    <= acc_d;
                cnt_q    <= cnt_d;
                avg_q    <= avg_d;
                avgv_q   <= avgv_d;
                orc_q    <= orc_d;
                sticky_q <= sticky_d;
                dac_q    <= dac_d;
            end
        end

        assign o_sample[c*DATA_W +: DATA_W] = samp_q;
        assign o_valid[c]                   = valid_q;
        assign o_avg[c*DATA_W +: DATA_W]    = avg_q;
        assign o_avg_valid[c]               = avgv_q;
        assign o_or_flag[c]                 = (orc_q != '0);
        assign o_or_sticky[c]               = sticky_q;
        assign o_dac[c*DATA_W +: DATA_W]    = dac_q;
    end

endmodule

// File: tb/tb_adc_sense_frontend.sv
// Self-checking bench for adc_sense_frontend: directed vector tables plus a randomized
// run checked every cycle against a behavioural reference model.
module tb_adc_sense_frontend;

    localparam int N    = 4;
    localparam int W    = 14;
    localparam int L    = 2;
    localparam int HOLD = 10;
    localparam int MAXV = 2**(W-1) - 1;
    localparam int MINV = -(2**(W-1));
    localparam int MID  = 2**(W-1);

    logic           clk = 1'b0;
    logic           rst, en, clr;
    logic [N*W-1:0] data, off, dbg;
    logic [N-1:0]   vld, orb, inv;
    logic [2*N-1:0] sel;
    logic [N*W-1:0] o_sample, o_avg, o_dac;
    logic [N-1:0]   o_valid, o_avg_valid, o_or_flag, o_or_sticky;

    adc_sense_frontend #(.N_CH(N), .DATA_W(W), .AVG_LOG2(L), .OR_HOLD(HOLD)) dut (
        .i_clock    (clk),
        .i_RESET    (rst),
        .i_enable   (en),
        .i_data     (data),
        .i_valid    (vld),
        .i_or       (orb),
        .i_invert   (inv),
        .i_offset   (off),
        .i_or_clear (clr),
        .i_dac_sel  (sel),
        .i_debug    (dbg),
        .o_sample   (o_sample),
        .o_valid    (o_valid),
        .o_avg      (o_avg),
        .o_avg_valid(o_avg_valid),
        .o_or_flag  (o_or_flag),
        .o_or_sticky(o_or_sticky),
        .o_dac      (o_dac)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state; inputs of the cycle before last are kept in p1_*.
    logic           p1_rst;
    logic [N-1:0]   p1_vld, p1_inv;
    logic [N*W-1:0] p1_data;
    int e_samp[N], e_avg[N], e_dac[N], w_sum[N], w_n[N], last_ev[N];
    bit e_ov[N], e_av[N], e_st[N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int sget(input logic [N*W-1:0] bus, input int c);
        logic signed [W-1:0] t;
        t = bus[c*W +: W];
        return int'(t);
    endfunction

    function automatic int cond(input int d, input bit iv, input int o);
        int x, y;
        x = iv ? ((d == MINV) ? MAXV : -d) : d;
        y = x - o;
        if (y > MAXV) y = MAXV;
        if (y < MINV) y = MINV;
        return y;
    endfunction

    function automatic int floor_div(input int s, input int k);
        if (s >= 0) return s / k;
        return -((-s + k - 1) / k);
    endfunction

    task automatic model_check();
        logic [N*W-1:0] xs, xa, xd;
        logic [N-1:0]   xov, xav, xfl, xst;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                e_samp[c] = 0; e_avg[c] = 0; e_ov[c] = 0; e_av[c] = 0; e_st[c] = 0;
                w_sum[c] = 0; w_n[c] = 0; last_ev[c] = -1000; e_dac[c] = MID;
            end else begin
                int s, sl;
                sl = int'(sel[2*c +: 2]);
                case (sl)
                    0:       s = e_samp[c];
                    1:       s = e_avg[c];
                    2:       s = sget(dbg, c);
                    default: s = 0;
                endcase
                e_dac[c] = s + MID;
                e_av[c] = 0;
                if (!en) begin
                    w_sum[c] = 0; w_n[c] = 0;
                end else if (e_ov[c]) begin
                    w_sum[c] += e_samp[c];
                    w_n[c]++;
                    if (w_n[c] == (1 << L)) begin
                        e_avg[c] = floor_div(w_sum[c], 1 << L);
                        e_av[c]  = 1;
                        w_sum[c] = 0; w_n[c] = 0;
                    end
                end
                e_ov[c] = p1_vld[c] && !p1_rst && en;
                if (p1_vld[c] && !p1_rst)
                    e_samp[c] = cond(sget(p1_data, c), p1_inv[c], sget(off, c));
                if (vld[c] && orb[c]) begin
                    e_st[c] = 1;
                    last_ev[c] = cyc - 1;
                end else if (clr) begin
                    e_st[c] = 0;
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            int sv, av, dv;
            sv = e_samp[c]; av = e_avg[c]; dv = e_dac[c];
            xs[c*W +: W] = sv[W-1:0];
            xa[c*W +: W] = av[W-1:0];
            xd[c*W +: W] = dv[W-1:0];
            xov[c] = e_ov[c];
            xav[c] = e_av[c];
            xst[c] = e_st[c];
            xfl[c] = (cyc - last_ev[c] >= 1) && (cyc - last_ev[c] <= HOLD);
        end
        chk("m_sample", o_sample, xs);
        chk("m_valid", o_valid, xov);
        chk("m_avg", o_avg, xa);
        chk("m_avg_valid", o_avg_valid, xav);
        chk("m_or_flag", o_or_flag, xfl);
        chk("m_or_sticky", o_or_sticky, xst);
        chk("m_dac", o_dac, xd);
        p1_rst = rst; p1_vld = vld; p1_inv = inv; p1_data = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_check();
    endtask

    task automatic set_w(inout logic [N*W-1:0] bus, input int c, input int v);
        bus[c*W +: W] = v[W-1:0];
    endtask

    task automatic feed(input int c, input int v);
        vld = '0;
        vld[c] = 1'b1;
        set_w(data, c, v);
        tick();
        vld = '0;
    endtask

    function automatic int rand_word();
        case ($urandom_range(0, 7))
            0:       return MINV;
            1:       return MAXV;
            default: return int'($urandom_range(0, 16383)) - MID;
        endcase
    endfunction

    typedef struct { int d; bit iv; int o; int exp; } inv_vec_t;
    typedef struct { int s; int dbgv; int exp; } dac_vec_t;

    inv_vec_t itab[5];
    dac_vec_t dtab[6];
    int avg_a[4], avg_b[4], avg_c[4];

    initial begin
        itab[0] = '{d: -8192, iv: 1, o: 0,    exp: 8191};
        itab[1] = '{d: 100,   iv: 1, o: 0,    exp: -100};
        itab[2] = '{d: 8100,  iv: 0, o: -200, exp: 8191};
        itab[3] = '{d: -8000, iv: 0, o: 300,  exp: -8192};
        itab[4] = '{d: -8192, iv: 1, o: 5,    exp: 8186};
        dtab[0] = '{s: 0, dbgv: 0,     exp: 8092};
        dtab[1] = '{s: 1, dbgv: 0,     exp: 8242};
        dtab[2] = '{s: 2, dbgv: 0,     exp: 8192};
        dtab[3] = '{s: 3, dbgv: 0,     exp: 8192};
        dtab[4] = '{s: 2, dbgv: -8192, exp: 0};
        dtab[5] = '{s: 2, dbgv: 8191,  exp: 16383};
        avg_a = '{1, 2, 3, 5};
        avg_b = '{-1, -1, -1, -2};
        avg_c = '{4, 4, 4, 8};

        rst = 1'b1; en = 1'b1; clr = 1'b0;
        data = '0; off = '0; dbg = '0; vld = '0; orb = '0; inv = '0; sel = '0;
        p1_rst = 1'b1; p1_vld = '0; p1_inv = '0; p1_data = '0;

        // Reset with valid toggling
        for (int i = 0; i < 3; i++) begin
            vld = (i % 2 == 0) ? '1 : '0;
            orb = '1;
            tick();
            chk("rst_valid", o_valid, '0);
            chk("rst_avg_valid", o_avg_valid, '0);
            chk("rst_sample", o_sample, '0);
            chk("rst_dac", o_dac, {N{14'h2000}});
            chk("rst_sticky", o_or_sticky, '0);
        end
        rst = 1'b0; vld = '0; orb = '0;
        tick();

        // Inversion / offset / saturation on ch0
        foreach (itab[i]) begin
            inv[0] = itab[i].iv;
            set_w(off, 0, itab[i].o);
            feed(0, itab[i].d);
            tick();
            chk("inv_valid", o_valid[0], 1'b1);
            chk("inv_sample", sget(o_sample, 0), itab[i].exp);
        end
        inv = '0; off = '0;
        rst = 1'b1; tick(); rst = 1'b0;

        // Averaging, including reset mid-window
        foreach (avg_a[i]) feed(0, avg_a[i]);
        tick(); tick();
        chk("avg1_valid", o_avg_valid[0], 1'b1);
        chk("avg1_value", sget(o_avg, 0), 2);
        foreach (avg_b[i]) feed(0, avg_b[i]);
        tick(); tick();
        chk("avg2_valid", o_avg_valid[0], 1'b1);
        chk("avg2_value", sget(o_avg, 0), -2);
        feed(0, 7); feed(0, 9);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        foreach (avg_c[i]) feed(0, avg_c[i]);
        tick(); tick();
        chk("avg3_valid", o_avg_valid[0], 1'b1);
        chk("avg3_value", sget(o_avg, 0), 5);

        // DAC mux: sample -100, average 50
        for (int i = 0; i < 4; i++) feed(0, 50);
        tick(); tick();
        feed(0, -100);
        tick(); tick();
        foreach (dtab[i]) begin
            sel[1:0] = dtab[i].s[1:0];
            set_w(dbg, 0, dtab[i].dbgv);
            tick();
            chk("dac_word", o_dac[W-1:0], dtab[i].exp);
        end
        sel = '0; dbg = '0;

        // OR stretch with re-trigger, then clear vs set priority
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            vld[1] = (k == 0 || k == 5);
            orb[1] = (k == 0 || k == 5);
            tick();
            chk("or_flag", o_or_flag[1], (k <= 14) ? 1'b1 : 1'b0);
        end
        vld[1] = 1'b1; orb[1] = 1'b1; clr = 1'b1;
        tick();
        chk("sticky_set_wins", o_or_sticky[1], 1'b1);
        vld = '0; orb = '0;
        tick();
        chk("sticky_cleared", o_or_sticky[1], 1'b0);
        clr = 1'b0;

        // Enable drop mid-window on ch2 while ch0 streams
        rst = 1'b1; tick(); rst = 1'b0;
        feed(2, 100); feed(2, 200);
        tick(); tick(); tick();
        en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vld = 4'b0001;
            if (i == 3) vld[2] = 1'b1;
            set_w(data, 0, i * 11);
            set_w(data, 2, 500);
            tick();
            chk("dis_valid", o_valid, '0);
            chk("dis_avg_valid", o_avg_valid, '0);
        end
        vld = '0;
        tick(); tick(); tick();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vld = 4'b0101;
            set_w(data, 2, 10 * (i + 1));
            set_w(data, 0, (i == 3) ? -4 : -3);
            tick();
        end
        vld = '0;
        tick(); tick();
        chk("en_avg_valid", o_avg_valid, 4'b0101);
        chk("en_avg_ch2", sget(o_avg, 2), 25);
        chk("en_avg_ch0", sget(o_avg, 0), -4);

        // Randomized run; enable/offset change only while valid is quiet
        for (int i = 0; i < 4000; i++) begin
            int ph;
            ph  = i % 100;
            rst = (ph == 50) && ($urandom_range(0, 7) == 0);
            if (ph == 2) begin
                en = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < N; c++) set_w(off, c, rand_word());
            end
            for (int c = 0; c < N; c++) begin
                vld[c] = (ph >= 6) && ($urandom_range(0, 1) == 1);
                orb[c] = ($urandom_range(0, 15) == 0);
                inv[c] = $urandom_range(0, 1) == 1;
                set_w(data, c, rand_word());
                set_w(dbg, c, rand_word());
                sel[2*c +: 2] = 2'($urandom_range(0, 3));
            end
            clr = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
